// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
//
// Memory-stage access controller. Sits between the EX/MEM pipeline register
// and a multi-cycle data cache. Exactly one cache request is issued per load
// or store. The pipeline is held with `stall` until the cache reports done.
// Completion is signalled with a one-cycle `done`, and load data is registered
// into `rdData` for the MEM/WB register.
//
// Optional feature macro: MEM_STAGE_STATS_EN
//   When defined, builds saturating request/hit counters.
//   When undefined, reqCount/hitCount read 0 and no counter registers exist.
//
// Parameters
//   TIMEOUT      : WAIT cycles without cacheDone before the access is declared
//                  failed (legal range 2..255)
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   isMemRead    : EX/MEM load
//   isMemWrite   : EX/MEM store (wins when both are set; also raises err)
//   addr, wrData : EX/MEM effective address and store data
//   cacheDataOut : cache read data, valid with cacheDone
//   cacheDone    : cache access complete (one-cycle pulse)
//   cacheStall   : cache busy, request not accepted
//   cacheHit     : completing access was a hit, valid with cacheDone
//   cacheAddr    : request address (live in IDLE, held while waiting)
//   cacheDataIn  : request write data (live in IDLE, held while waiting)
//   cacheRd      : one-cycle read request
//   cacheWr      : one-cycle write request
//   stall        : freeze the upstream pipeline
//   done         : access completed this cycle
//   rdData       : registered load data
//   err          : sticky error (read+write conflict or timeout)
//   reqCount     : issued requests (statistics)
//   hitCount     : completed hits (statistics)
// -----------------------------------------------------------------------------
module mem_stage_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        isMemRead,
    input  logic        isMemWrite,
    input  logic [15:0] addr,
    input  logic [15:0] wrData,
    input  logic [15:0] cacheDataOut,
    input  logic        cacheDone,
    input  logic        cacheStall,
    input  logic        cacheHit,
    output logic [15:0] cacheAddr,
    output logic [15:0] cacheDataIn,
    output logic        cacheRd,
    output logic        cacheWr,
    output logic        stall,
    output logic        done,
    output logic [15:0] rdData,
    output logic        err,
    output logic [15:0] reqCount,
    output logic [15:0] hitCount
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Last WAIT count value before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]  state_r;
    logic [15:0] hold_addr_r;
    logic [15:0] hold_data_r;
    logic        hold_load_r;
    logic [7:0]  wait_cnt_r;
    logic        timeout_err_r;
    logic        err_r;
    logic [15:0] rd_data_r;

    logic        access_s;
    logic        in_idle_s;
    logic        issue_s;
    logic        complete_s;
    logic        cur_load_s;

    // Request/completion decode. Reset suppresses requests and completions so
    // the cache (which shares rst) never sees a request it will discard.
    always_comb begin
        access_s   = isMemRead | isMemWrite;
        in_idle_s  = (state_r == ST_IDLE);
        issue_s    = in_idle_s & access_s & ~cacheStall & ~timeout_err_r & ~rst;
        complete_s = ((issue_s & cacheDone) | (~in_idle_s & cacheDone)) & ~rst;
        if (in_idle_s) begin
            cur_load_s = isMemRead & ~isMemWrite;
        end else begin
            cur_load_s = hold_load_r;
        end
    end

    // Output equations: request strobes only in the issue cycle, address and
    // data come from the holding registers while a request is outstanding.
    always_comb begin
        cacheRd = issue_s & isMemRead & ~isMemWrite;
        cacheWr = issue_s & isMemWrite;
        done    = complete_s;
        stall   = (in_idle_s & access_s & ~(issue_s & cacheDone))
                | (~in_idle_s & ~cacheDone)
                | timeout_err_r;
        if (in_idle_s) begin
            cacheAddr   = addr;
            cacheDataIn = wrData;
        end else begin
            cacheAddr   = hold_addr_r;
            cacheDataIn = hold_data_r;
        end
    end

    // Access FSM, holding registers and WAIT timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            hold_addr_r   <= 16'h0000;
            hold_data_r   <= 16'h0000;
            hold_load_r   <= 1'b0;
            wait_cnt_r    <= 8'd0;
            timeout_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        hold_addr_r <= addr;
                        hold_data_r <= wrData;
                        hold_load_r <= isMemRead & ~isMemWrite;
                        if (!cacheDone) begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= 8'd0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cacheDone) begin
                        state_r <= ST_IDLE;
                    end else if (wait_cnt_r == TIMEOUT_LAST) begin
                        // Cache never answered: park in IDLE and hold the pipe.
                        state_r       <= ST_IDLE;
                        timeout_err_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error: read/write conflict at issue, or a WAIT timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (issue_s && isMemRead && isMemWrite) begin
            err_r <= 1'b1;
        end else if (!in_idle_s && !cacheDone && wait_cnt_r == TIMEOUT_LAST) begin
            err_r <= 1'b1;
        end
    end

    // Load data register, updated only when a load completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 16'h0000;
        end else if (complete_s && cur_load_s) begin
            rd_data_r <= cacheDataOut;
        end
    end

    assign err    = err_r;
    assign rdData = rd_data_r;

`ifdef MEM_STAGE_STATS_EN
    logic [15:0] req_cnt_r;
    logic [15:0] hit_cnt_r;

    // Saturating request and hit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt_r <= 16'h0000;
            hit_cnt_r <= 16'h0000;
        end else begin
            if (issue_s && req_cnt_r != 16'hFFFF) begin
                req_cnt_r <= req_cnt_r + 16'h0001;
            end
            if (complete_s && cacheHit && hit_cnt_r != 16'hFFFF) begin
                hit_cnt_r <= hit_cnt_r + 16'h0001;
            end
        end
    end

    assign reqCount = req_cnt_r;
    assign hitCount = hit_cnt_r;
`else
    // cacheHit only feeds the statistics; keep it visibly consumed.
    logic unused_hit_s;
    assign unused_hit_s = cacheHit;
    assign reqCount     = 16'h0000;
    assign hitCount     = 16'h0000;
`endif

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage access controller. Sits between the EX/MEM pipeline register and the multi-cycle data cache / memory system. It issues exactly one cache request per load or store and holds the pipeline with `stall` until the cache reports `Done`. It then pulses `done` and registers load data for the MEM/WB register. The writeback-stage `RegWrite`/`MemRead` qualification consumes its `stall` and `done` outputs.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles spent in WAIT without `cacheDone` before declaring an error; legal range 2–255.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `isMemRead`  in  1  EX/MEM: instruction is a load
- `isMemWrite`  in  1  EX/MEM: instruction is a store
- `addr`  in  16  EX/MEM: effective address (ALU result)
- `wrData`  in  16  EX/MEM: store data
- `cacheDataOut`  in  16  cache read data, valid when `cacheDone`
- `cacheDone`  in  1  cache: access complete (one-cycle pulse)
- `cacheStall`  in  1  cache busy; no new request accepted
- `cacheHit`  in  1  cache: completing access was a hit, valid with `cacheDone`
- `cacheAddr`  out  16  request address
- `cacheDataIn`  out  16  request write data
- `cacheRd`  out  1  read request, one cycle
- `cacheWr`  out  1  write request, one cycle
- `stall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- `done`  out  1  access completed this cycle
- `rdData`  out  16  registered load data
- `err`  out  1  sticky error flag
- `reqCount`  out  16  issued requests (statistics)
- `hitCount`  out  16  completed hits (statistics)

## Operation
- `access = isMemRead | isMemWrite`. With both set, the access is a write and `err` is set (sticky).
- FSM states: IDLE and WAIT.
- IDLE, `access & ~cacheStall`:
  - Assert `cacheRd` or `cacheWr` combinationally for this cycle only.
  - Latch addr, wrData and type into holding registers.
  - If `cacheDone` is also high this cycle (same-cycle hit), complete immediately and stay in IDLE.
  - Otherwise go to WAIT.
- IDLE, `access & cacheStall`: no request; `stall=1`; retry every cycle.
- WAIT:
  - No request outputs.
  - `cacheAddr`/`cacheDataIn` driven from the holding registers. In IDLE they are driven from `addr`/`wrData`.
  - On `cacheDone`: complete and go to IDLE.
- Completion:
  - `done=1` for that cycle.
  - If the access is a load, `rdData <= cacheDataOut` at that edge.
  - `rdData` holds its value otherwise.
- `stall = (IDLE & access & ~(issue & cacheDone)) | (WAIT & ~cacheDone) | timeoutErr`.
- Timeout:
  - A WAIT cycle counter resets on entry to WAIT.
  - When it reaches `TIMEOUT` with no `cacheDone`: set `err`, set `timeoutErr` (sticky), go to IDLE.
  - While `timeoutErr` is set: `stall=1` permanently, no further requests.
- A `cacheDone` arriving in IDLE without an outstanding request is ignored and produces no `done`.
- Reset: state IDLE, counters 0, `timeoutErr` 0. The cache shares `rst`, so no outstanding request survives reset.

## Timing
- Reset values: `cacheRd=cacheWr=0`, `done=0`, `rdData=0x0000`, `err=0`, `reqCount=hitCount=0`. `stall`, `cacheAddr` and `cacheDataIn` follow their combinational equations (`stall=access`).
- Hit latency:
  - 0 extra cycles when the cache returns Done in the request cycle (`stall=0`, `done=1` in that cycle).
  - N-cycle cache: `stall` high for N cycles; `done` in cycle N.
- `rdData` is valid in the cycle after `done`, aligned with the MEM/WB register.
- Request outputs are never asserted in two consecutive cycles for the same access.

## Configuration
- `MEM_STAGE_STATS_EN` defined:
  - `reqCount` increments on each issued request.
  - `hitCount` increments on each completion with `cacheHit=1`.
  - Both saturate at 0xFFFF and reset to 0.
- Not defined: both outputs tied to 0x0000 and no counter registers are built. The port list is unchanged.

## Test plan
- Load, `addr=0x0010`, cache returns Done+Hit with `cacheDataOut=0xBEEF` in the request cycle -> `cacheRd` one cycle, `stall=0`, `done=1`; `rdData=0xBEEF` next cycle.
- Store, `addr=0x0020`, `wrData=0x1234`, Done after 4 cycles -> `cacheWr` one cycle with `cacheAddr=0x0020`, `cacheDataIn=0x1234`; `stall` high 4 cycles; `done` in cycle 4; `rdData` unchanged.
- Load while `cacheStall=1` for 3 cycles -> no request for 3 cycles, `stall=1`; request issued in cycle 4.
- `TIMEOUT=8`, load, no Done -> `err=1` after 8 WAIT cycles; `stall` held high; no further requests; `rst` clears everything.
- `isMemRead=isMemWrite=1` -> `cacheWr` only, `err=1`. Separately, `rst` mid-WAIT -> state IDLE and `stall=access` next cycle; a stray `cacheDone` after reset produces no `done`.
- With `MEM_STAGE_STATS_EN`: 3 hits and 2 misses -> `reqCount=5`, `hitCount=3`. Without the macro: both outputs read 0.
